// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and PC/IF_ID write enables.
// Latency: one cycle from ID inputs to ID_EX_* outputs; hazard and enable outputs are combinational.
// Backpressure: Freeze holds everything; a load-use hazard holds PC/IF_ID and inserts one bubble.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic [4:0]        IF_ID_Rd,
    input  logic [DATA_W-1:0] ID_ReadData1,
    input  logic [DATA_W-1:0] ID_ReadData2,
    input  logic [DATA_W-1:0] ID_SignExt,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemtoReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_RegDst,
    input  logic [1:0]        ID_ALUOp,
    input  logic              ID_Flush,
    input  logic              Freeze,
    output logic [4:0]        ID_EX_Rs,
    output logic [4:0]        ID_EX_Rt,
    output logic [4:0]        ID_EX_Rd,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_SignExt,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemtoReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_RegDst,
    output logic [1:0]        ID_EX_ALUOp,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              HazardStall,
    output logic [CNT_W-1:0]  StallCount
);

    // Everything the EX stage needs from ID, kept as one packed word so
    // reset, hold, bubble and load are each a single assignment.
    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] readData1;
        logic [DATA_W-1:0] readData2;
        logic [DATA_W-1:0] signExt;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memtoReg;
        logic              aluSrc;
        logic              regDst;
        logic [1:0]        aluOp;
    } idExT;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    idExT             idExQ;
    idExT             idExD;
    logic             loadUse;
    logic             bubble;
    logic [CNT_W-1:0] stallCountQ;

    // Gather the ID-stage inputs into the register image.
    always_comb begin
        idExD           = '0;
        idExD.rs        = IF_ID_Rs;
        idExD.rt        = IF_ID_Rt;
        idExD.rd        = IF_ID_Rd;
        idExD.readData1 = ID_ReadData1;
        idExD.readData2 = ID_ReadData2;
        idExD.signExt   = ID_SignExt;
        idExD.regWrite  = ID_RegWrite;
        idExD.memRead   = ID_MemRead;
        idExD.memWrite  = ID_MemWrite;
        idExD.memtoReg  = ID_MemtoReg;
        idExD.aluSrc    = ID_ALUSrc;
        idExD.regDst    = ID_RegDst;
        idExD.aluOp     = ID_ALUOp;
    end

    // Load in EX whose destination is a source of the instruction in ID.
    // $0 never creates a dependency. A flush squashes the dependent
    // instruction, and a freeze defers the decision until the pipe moves.
    always_comb begin
        loadUse     = idExQ.memRead && (idExQ.rt != 5'd0) &&
                      ((idExQ.rt == IF_ID_Rs) || (idExQ.rt == IF_ID_Rt));
        HazardStall = loadUse && !ID_Flush && !Freeze;
        PCWrite     = !(HazardStall || Freeze);
        IF_ID_Write = !(HazardStall || Freeze);
        bubble      = ID_Flush || HazardStall;
    end

    // Pipeline register: reset, then hold on freeze, then bubble, else load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idExQ <= '0;
        end else if (Freeze) begin
            idExQ <= idExQ;
        end else if (bubble) begin
            idExQ <= '0;
        end else begin
            idExQ <= idExD;
        end
    end

    // Count inserted load-use bubbles, saturating; flush-only bubbles are not counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCountQ <= '0;
        end else if (HazardStall && (stallCountQ != CNT_MAX)) begin
            stallCountQ <= stallCountQ + 1'b1;
        end
    end

    // Registered outputs.
    always_comb begin
        ID_EX_Rs        = idExQ.rs;
        ID_EX_Rt        = idExQ.rt;
        ID_EX_Rd        = idExQ.rd;
        ID_EX_ReadData1 = idExQ.readData1;
        ID_EX_ReadData2 = idExQ.readData2;
        ID_EX_SignExt   = idExQ.signExt;
        ID_EX_RegWrite  = idExQ.regWrite;
        ID_EX_MemRead   = idExQ.memRead;
        ID_EX_MemWrite  = idExQ.memWrite;
        ID_EX_MemtoReg  = idExQ.memtoReg;
        ID_EX_ALUSrc    = idExQ.aluSrc;
        ID_EX_RegDst    = idExQ.regDst;
        ID_EX_ALUOp     = idExQ.aluOp;
        StallCount      = stallCountQ;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a full-width counter instance and a 2-bit
// counter instance share all inputs so saturation can be seen quickly.
// Inputs change 1 time unit after the rising edge; outputs are read away from the edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic [31:0] ID_ReadData1, ID_ReadData2, ID_SignExt;
    logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
    logic [1:0]  ID_ALUOp;
    logic        ID_Flush, Freeze;

    logic [4:0]  exRs, exRt, exRd;
    logic [31:0] exRd1, exRd2, exSext;
    logic        exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluSrc, exRegDst;
    logic [1:0]  exAluOp;
    logic        pcWrite, ifIdWrite, hazardStall;
    logic [15:0] stallCount;

    logic [4:0]  sRs, sRt, sRd;
    logic [31:0] sRd1, sRd2, sSext;
    logic        sRegWrite, sMemRead, sMemWrite, sMemtoReg, sAluSrc, sRegDst;
    logic [1:0]  sAluOp;
    logic        sPcWrite, sIfIdWrite, sHazardStall;
    logic [1:0]  sStallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_ALUOp(ID_ALUOp), .ID_Flush(ID_Flush), .Freeze(Freeze),
        .ID_EX_Rs(exRs), .ID_EX_Rt(exRt), .ID_EX_Rd(exRd),
        .ID_EX_ReadData1(exRd1), .ID_EX_ReadData2(exRd2), .ID_EX_SignExt(exSext),
        .ID_EX_RegWrite(exRegWrite), .ID_EX_MemRead(exMemRead), .ID_EX_MemWrite(exMemWrite),
        .ID_EX_MemtoReg(exMemtoReg), .ID_EX_ALUSrc(exAluSrc), .ID_EX_RegDst(exRegDst),
        .ID_EX_ALUOp(exAluOp), .PCWrite(pcWrite), .IF_ID_Write(ifIdWrite),
        .HazardStall(hazardStall), .StallCount(stallCount)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd),
        .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExt(ID_SignExt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_ALUOp(ID_ALUOp), .ID_Flush(ID_Flush), .Freeze(Freeze),
        .ID_EX_Rs(sRs), .ID_EX_Rt(sRt), .ID_EX_Rd(sRd),
        .ID_EX_ReadData1(sRd1), .ID_EX_ReadData2(sRd2), .ID_EX_SignExt(sSext),
        .ID_EX_RegWrite(sRegWrite), .ID_EX_MemRead(sMemRead), .ID_EX_MemWrite(sMemWrite),
        .ID_EX_MemtoReg(sMemtoReg), .ID_EX_ALUSrc(sAluSrc), .ID_EX_RegDst(sRegDst),
        .ID_EX_ALUOp(sAluOp), .PCWrite(sPcWrite), .IF_ID_Write(sIfIdWrite),
        .HazardStall(sHazardStall), .StallCount(sStallCount)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] allEx();
        return {exRs, exRt, exRd, exRd1, exRd2, exSext, exRegWrite, exMemRead,
                exMemWrite, exMemtoReg, exAluSrc, exRegDst, exAluOp};
    endfunction

    function automatic logic [127:0] allCtrl();
        return {exRegWrite, exMemRead, exMemWrite, exMemtoReg, exAluSrc, exRegDst, exAluOp};
    endfunction

    task automatic idle();
        IF_ID_Rs = 0; IF_ID_Rt = 0; IF_ID_Rd = 0;
        ID_ReadData1 = 0; ID_ReadData2 = 0; ID_SignExt = 0;
        ID_RegWrite = 0; ID_MemRead = 0; ID_MemWrite = 0;
        ID_MemtoReg = 0; ID_ALUSrc = 0; ID_RegDst = 0; ID_ALUOp = 0;
        ID_Flush = 0; Freeze = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put "lw $rt, 4($1)" into ID and clock it into EX.
    task automatic loadLw(input logic [4:0] rt);
        idle();
        IF_ID_Rs = 5'd1; IF_ID_Rt = rt; ID_SignExt = 32'd4;
        ID_RegWrite = 1; ID_MemRead = 1; ID_MemtoReg = 1; ID_ALUSrc = 1;
        tick();
    endtask

    // Dependent "add $10, $rs, $9" sitting in ID.
    task automatic driveAdd(input logic [4:0] rs);
        idle();
        IF_ID_Rs = rs; IF_ID_Rt = 5'd9; IF_ID_Rd = 5'd10;
        ID_ReadData1 = 32'h22; ID_ReadData2 = 32'h33;
        ID_RegWrite = 1; ID_RegDst = 1; ID_ALUOp = 2'b10;
    endtask

    logic [1:0] satExp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        // Reset with random inputs for two edges.
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            IF_ID_Rs = 5'($urandom); IF_ID_Rt = 5'($urandom); IF_ID_Rd = 5'($urandom);
            ID_ReadData1 = $urandom; ID_ReadData2 = $urandom; ID_SignExt = $urandom;
            {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst} = 6'($urandom);
            ID_ALUOp = 2'($urandom); ID_Flush = 1'($urandom); Freeze = 1'($urandom);
            tick();
        end
        idle();
        #1;
        checkVal("reset_idex", allEx(), 128'd0);
        checkVal("reset_cnt", 128'(stallCount), 128'd0);
        checkVal("reset_pcwrite", 128'(pcWrite), 128'd1);
        checkVal("reset_ifidwrite", 128'(ifIdWrite), 128'd1);
        checkVal("reset_hazard", 128'(hazardStall), 128'd0);
        rst_n = 1;

        // Normal pass-through.
        idle();
        IF_ID_Rs = 5'd3; IF_ID_Rt = 5'd4; IF_ID_Rd = 5'd5;
        ID_ReadData1 = 32'h11; ID_RegWrite = 1; ID_ALUOp = 2'b10;
        #1;
        checkVal("pass_hazard", 128'(hazardStall), 128'd0);
        tick();
        checkVal("pass_regs", {exRs, exRt, exRd, exRd1},
                 {5'd3, 5'd4, 5'd5, 32'h11});
        checkVal("pass_ctrl", allCtrl(), {8'b1000_0010});

        // Load-use: lw $8 then add using $8.
        loadLw(5'd8);
        checkVal("lw_in_ex", {exRt, exMemRead}, {5'd8, 1'b1});
        driveAdd(5'd8);
        #1;
        checkVal("lu_hazard", 128'(hazardStall), 128'd1);
        checkVal("lu_pcwrite", 128'(pcWrite), 128'd0);
        checkVal("lu_ifidwrite", 128'(ifIdWrite), 128'd0);
        tick();
        checkVal("lu_bubble_ctrl", allCtrl(), 128'd0);
        checkVal("lu_bubble_regs", {exRs, exRt, exRd, exRd1}, 128'd0);
        checkVal("lu_cnt", 128'(stallCount), 128'd1);
        checkVal("sat_cnt0", 128'(sStallCount), 128'(satExp[0]));
        checkVal("lu_after_hazard", 128'(hazardStall), 128'd0);
        checkVal("lu_after_pcwrite", 128'(pcWrite), 128'd1);
        tick();
        checkVal("lu_add_loaded", {exRs, exRd, exRd1, exRegWrite}, {5'd8, 5'd10, 32'h22, 1'b1});

        // No hazard through $0.
        loadLw(5'd0);
        idle();
        ID_RegWrite = 1;
        #1;
        checkVal("zero_hazard", 128'(hazardStall), 128'd0);
        tick();
        checkVal("zero_cnt", 128'(stallCount), 128'd1);

        // Load-use coinciding with a flush.
        loadLw(5'd8);
        driveAdd(5'd8);
        ID_Flush = 1;
        #1;
        checkVal("flush_hazard", 128'(hazardStall), 128'd0);
        checkVal("flush_pcwrite", 128'(pcWrite), 128'd1);
        tick();
        checkVal("flush_bubble", allEx(), 128'd0);
        checkVal("flush_cnt", 128'(stallCount), 128'd1);

        // Load-use held under Freeze for three cycles.
        loadLw(5'd8);
        driveAdd(5'd8);
        Freeze = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkVal("frz_hazard", 128'(hazardStall), 128'd0);
            checkVal("frz_pcwrite", 128'(pcWrite), 128'd0);
            tick();
            checkVal("frz_hold", {exRs, exRt, exMemRead, exSext}, {5'd1, 5'd8, 1'b1, 32'd4});
            checkVal("frz_cnt", 128'(stallCount), 128'd1);
        end
        Freeze = 0;
        #1;
        checkVal("unfrz_hazard", 128'(hazardStall), 128'd1);
        tick();
        checkVal("unfrz_bubble", 128'(exMemRead), 128'd0);
        checkVal("unfrz_cnt", 128'(stallCount), 128'd2);
        checkVal("sat_cnt1", 128'(sStallCount), 128'(satExp[1]));
        tick();
        checkVal("unfrz_add", {exRs, exRd}, {5'd8, 5'd10});

        // Three more stalls: 2-bit counter saturates, 16-bit one keeps counting.
        for (int k = 2; k < 5; k++) begin
            loadLw(5'd7);
            driveAdd(5'd7);
            tick();
            checkVal("sat_cnt", 128'(sStallCount), 128'(satExp[k]));
            checkVal("wide_cnt", 128'(stallCount), 128'(k + 1));
        end

        // Reset in the middle of a stall.
        loadLw(5'd8);
        driveAdd(5'd8);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        checkVal("midrst_idex", allEx(), 128'd0);
        checkVal("midrst_cnt", 128'(stallCount), 128'd0);
        checkVal("midrst_hazard", 128'(hazardStall), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage pipeline, combined with load-use hazard detection. It captures decoded control, register numbers and operands from ID. It inserts a one-cycle bubble on a load-use dependency or a branch flush, and generates the PC/IF_ID write enables. Its `ID_EX_Rs`, `ID_EX_Rt` and `ID_EX_Rd` outputs drive the forwarding unit and the EX stage directly.

## Interface
- `DATA_W`, 32 — width of operand and immediate fields
- `CNT_W`, 16 — width of the load-use stall counter

Clock/reset: one clock; reset is synchronous and active-low.

- `clk` in 1 — pipeline clock, rising edge
- `rst_n` in 1 — synchronous active-low reset
- `IF_ID_Rs`, `IF_ID_Rt`, `IF_ID_Rd` in 5 each — register numbers decoded in ID
- `ID_ReadData1`, `ID_ReadData2`, `ID_SignExt` in DATA_W each — register file reads and extended immediate
- `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemtoReg`, `ID_ALUSrc`, `ID_RegDst` in 1 each — control from decoder
- `ID_ALUOp` in 2 — ALU op class
- `ID_Flush` in 1 — branch/jump taken; the instruction in ID is squashed
- `Freeze` in 1 — global hold (e.g. memory wait); the whole front end holds
- `ID_EX_*` out (widths as inputs) — registered copies: Rs, Rt, Rd, ReadData1, ReadData2, SignExt, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp
- `PCWrite` out 1 — PC update enable
- `IF_ID_Write` out 1 — IF/ID register enable
- `HazardStall` out 1 — load-use bubble being inserted this cycle
- `StallCount` out CNT_W — number of load-use bubbles inserted since reset

## Operation
- **LoadUse** (combinational) = `ID_EX_MemRead` && (`ID_EX_Rt` != 0) && (`ID_EX_Rt` == `IF_ID_Rs` || `ID_EX_Rt` == `IF_ID_Rt`).
- **HazardStall** = LoadUse && !`ID_Flush` && !`Freeze`. A flush squashes the dependent instruction, so no stall is needed.
- **PCWrite** = **IF_ID_Write** = !(HazardStall || `Freeze`).
- Register update at each rising edge, highest priority first:
  1. `!rst_n`: all `ID_EX_*` = 0, `StallCount` = 0.
  2. `Freeze`: all `ID_EX_*` and `StallCount` hold.
  3. `ID_Flush` or HazardStall: bubble.
     - All control outputs = 0.
     - Rs, Rt, Rd = 0, so the forwarding unit sees no match.
     - Data fields = 0.
  4. Otherwise: load all `ID_*` / `IF_ID_*` inputs.
- **StallCount**:
  - Increments by 1 on each edge where HazardStall = 1 (case 3 via LoadUse).
  - Saturates at 2^CNT_W−1; no wrap.
  - Flush-only bubbles are not counted.
- The block keeps no other state. Stall length is inherently one cycle: after the bubble, `ID_EX_MemRead` = 0, so LoadUse clears.

## Timing
- Latency: ID inputs appear on `ID_EX_*` one cycle after the capturing edge.
- `PCWrite`, `IF_ID_Write` and `HazardStall` are combinational from current `ID_EX_*` regs plus the `IF_ID_*`, `ID_Flush` and `Freeze` inputs. They are valid in the same cycle and must settle before the edge.
- Load-use sequence:
  - Cycle N: lw is in EX and the dependent instruction is in ID; HazardStall = 1.
  - Edge N→N+1: bubble enters EX; PC and IF/ID hold.
  - Cycle N+1: HazardStall = 0; the dependent instruction is captured at edge N+1→N+2. It then forwards from MEM/WB.
- Reset values: every `ID_EX_*` = 0, `StallCount` = 0. Hence after reset `PCWrite` = `IF_ID_Write` = 1 and `HazardStall` = 0, unless `Freeze` = 1.
- Reset asserted mid-stall: the register clears at that edge and the stall ends the next cycle.
- `Freeze` during a pending LoadUse: HazardStall is held low. The hazard is re-evaluated after `Freeze` drops, because the ID_EX contents held.
- `ID_Flush` and LoadUse in the same cycle: bubble inserted, `PCWrite` = 1 (the branch target loads), counter unchanged.

## Test plan
- **Reset.** Hold `rst_n` = 0 for 2 edges with random inputs → all `ID_EX_*` = 0, `StallCount` = 0, `PCWrite` = 1.
- **Normal pass-through.**
  - Stimulus: `IF_ID_Rs` = 3, `Rt` = 4, `Rd` = 5, `ReadData1` = 0x11, `ID_RegWrite` = 1, `ALUOp` = 2'b10.
  - Response: next cycle `ID_EX_Rs` = 3, `ID_EX_Rt` = 4, `ID_EX_Rd` = 5, `ID_EX_ReadData1` = 0x11, `ID_EX_RegWrite` = 1, `ID_EX_ALUOp` = 2'b10; `HazardStall` = 0.
- **Load-use.**
  - Stimulus: EX holds lw with `ID_EX_Rt` = 8, `MemRead` = 1; ID holds add with `IF_ID_Rs` = 8.
  - Response: `HazardStall` = 1, `PCWrite` = 0, `IF_ID_Write` = 0. Next cycle `ID_EX` controls = 0, `ID_EX_Rs` = 0, `StallCount` = 1. The following cycle the add loads normally with `ID_EX_Rs` = 8.
- **No hazard on $0.** lw with `ID_EX_Rt` = 0 and `IF_ID_Rt` = 0 → `HazardStall` = 0, `StallCount` unchanged.
- **Flush and Freeze priority.**
  - Load-use + `ID_Flush` = 1 → bubble, `PCWrite` = 1, `StallCount` unchanged.
  - Load-use + `Freeze` = 1 for 3 cycles → `ID_EX_*` hold lw values, `PCWrite` = 0, `HazardStall` = 0. Single stall occurs after `Freeze` drops.
- **Saturation.** With `CNT_W` = 2, force 5 load-use stalls → `StallCount` sequence 1, 2, 3, 3, 3.
